// File: rtl/clk_wiz_vio_if.sv
// Probe bus between the processor-side debug logic and clk_wiz_vio.
//   w_probe   : 32-bit probe value (core result register)
//   w_hold    : freeze probe capture
//   w_probe_q : captured probe value
//   w_chg     : one-cycle pulse when the captured value changes
//   w_cnt     : saturating count of captured changes
//   w_par     : byte parity of w_probe_q (zero when parity is compiled out)
// master drives w_probe/w_hold; slave (clk_wiz_vio) drives the results.
interface clk_wiz_vio_if;
  logic [31:0] w_probe;
  logic        w_hold;
  logic [31:0] w_probe_q;
  logic        w_chg;
  logic [15:0] w_cnt;
  logic [3:0]  w_par;

  modport master (
    output w_probe, w_hold,
    input  w_probe_q, w_chg, w_cnt, w_par
  );

  modport slave (
    input  w_probe, w_hold,
    output w_probe_q, w_chg, w_cnt, w_par
  );
endinterface

// File: rtl/clk_wiz_vio.sv
// clk_wiz_vio: board-level clock divider with lock indicator plus a probe
// capture register that tracks value changes of the core result.
// Ports:
//   w_clk    : reference clock, all logic on rising edge
//   w_rst    : synchronous active-high reset
//   w_clk2   : w_clk / DIV, 50% duty
//   w_locked : high once LOCK_CYCLES edges have passed since reset release
//   vio      : probe bus (clk_wiz_vio_if.slave)
// Parameters: DIV (even, >= 2), LOCK_CYCLES (1..65535).
// Optional feature: define CLKWIZ_VIO_PARITY_EN to register a byte-parity
// nibble of w_probe_q on w_par; otherwise w_par is tied to zero.
module clk_wiz_vio #(
  parameter int DIV         = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic        w_clk2,
  output logic        w_locked,
  clk_wiz_vio_if.slave vio
);

  localparam int              HALF     = DIV / 2;
  localparam int              DW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(HALF - 1);
  localparam logic [15:0]     LOCK_N   = 16'(LOCK_CYCLES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          clk2_q, clk2_d;
  logic [15:0]   lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic [31:0]   probe_q_q, probe_q_d;
  logic          chg_q, chg_d;
  logic [15:0]   cnt_q, cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    clk2_d    = clk2_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      clk2_d    = ~clk2_q;
    end

    lock_cnt_d = (lock_cnt_q < LOCK_N) ? lock_cnt_q + 16'd1 : lock_cnt_q;
    // Counter never moves past LOCK_N, so this stays high until reset.
    locked_d   = (lock_cnt_d == LOCK_N);

    // Capture is gated by the registered lock flag, so the first capture
    // lands one edge after w_locked rises.
    probe_q_d = probe_q_q;
    chg_d     = 1'b0;
    cnt_d     = cnt_q;
    if (locked_q && !vio.w_hold) begin
      probe_q_d = vio.w_probe;
      chg_d     = (vio.w_probe != probe_q_q);
      if (chg_d) cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      div_cnt_q  <= '0;
      clk2_q     <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      probe_q_q  <= '0;
      chg_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      clk2_q     <= clk2_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      probe_q_q  <= probe_q_d;
      chg_q      <= chg_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef CLKWIZ_VIO_PARITY_EN
  function automatic logic [3:0] byte_parity(input logic [31:0] v);
    return {^v[31:24], ^v[23:16], ^v[15:8], ^v[7:0]};
  endfunction

  logic [3:0] par_q, par_d;

  // Parity of the already-captured value, hence one cycle behind w_probe_q.
  always_comb par_d = byte_parity(probe_q_q);

  always_ff @(posedge w_clk) begin
    if (w_rst) par_q <= 4'b0000;
    else       par_q <= par_d;
  end

  assign vio.w_par = par_q;
`else
  assign vio.w_par = 4'b0000;
`endif

  assign w_clk2        = clk2_q;
  assign w_locked      = locked_q;
  assign vio.w_probe_q = probe_q_q;
  assign vio.w_chg     = chg_q;
  assign vio.w_cnt     = cnt_q;

endmodule

// File: tb/tb_clk_wiz_vio.sv
module tb_clk_wiz_vio;
  localparam int DIV  = 6;
  localparam int LOCK = 4;
  localparam int HALF = DIV / 2;

  typedef struct {
    logic        clk2;
    logic        locked;
    logic [31:0] probe_q;
    logic        chg;
    logic [15:0] cnt;
    logic [3:0]  par;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w_clk2, w_locked;

  clk_wiz_vio_if vio ();

  clk_wiz_vio #(.DIV(DIV), .LOCK_CYCLES(LOCK)) dut (
    .w_clk    (clk),
    .w_rst    (rst),
    .w_clk2   (w_clk2),
    .w_locked (w_locked),
    .vio      (vio.slave)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release and captured view.
  int          m_n   = 0;
  logic [31:0] m_q   = '0;
  logic        m_chg = 1'b0;
  int          m_cnt = 0;
  logic [3:0]  m_par = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_par(input logic [31:0] v);
    int ones;
    logic [3:0] r;
    for (int b = 0; b < 4; b++) begin
      ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(v[b*8+k]);
      r[b] = ((ones % 2) == 1);
    end
    return r;
  endfunction

  // Drive one edge's inputs and push what the outputs must be after it.
  task automatic step(input logic r, input logic [31:0] p, input logic h);
    exp_t e;
    @(negedge clk);
    rst = r;
    vio.w_probe = p;
    vio.w_hold = h;
    if (r) begin
      m_n = 0; m_q = '0; m_chg = 1'b0; m_cnt = 0; m_par = '0;
    end else begin
`ifdef CLKWIZ_VIO_PARITY_EN
      m_par = ref_par(m_q);
`else
      m_par = 4'b0000;
`endif
      if (m_n >= LOCK && !h) begin
        m_chg = (p != m_q);
        if (m_chg && m_cnt < 65535) m_cnt++;
        m_q = p;
      end else begin
        m_chg = 1'b0;
      end
      m_n++;
    end
    e.clk2    = ((m_n / HALF) % 2) == 1;
    e.locked  = (m_n >= LOCK);
    e.probe_q = m_q;
    e.chg     = m_chg;
    e.cnt     = 16'(m_cnt);
    e.par     = m_par;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("clk2",    {31'b0, w_clk2},        {31'b0, e.clk2});
        check("locked",  {31'b0, w_locked},      {31'b0, e.locked});
        check("probe_q", vio.w_probe_q,          e.probe_q);
        check("chg",     {31'b0, vio.w_chg},     {31'b0, e.chg});
        check("cnt",     {16'b0, vio.w_cnt},     {16'b0, e.cnt});
        check("par",     {28'b0, vio.w_par},     {28'b0, e.par});
      end
    end
  end

  initial begin
    logic [31:0] p;
    logic [31:0] last_p;
    rst = 1'b1;
    vio.w_probe = 32'h0000_0037;
    vio.w_hold = 1'b0;

    // Reset, then constant probe: single change pulse at first capture.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h37, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h37, 1'b0);

    // Randomized probe/hold traffic, with frequent repeats.
    last_p = 32'h37;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       p = last_p;
        1:       p = $urandom_range(0, 3);
        default: p = $urandom;
      endcase
      last_p = p;
      step(1'b0, p, ($urandom_range(0, 3) == 0));
    end

    // Hold while the probe walks 1->2->3, then release on 3.
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h1, 1'b1);
    step(1'b0, 32'h2, 1'b1);
    step(1'b0, 32'h3, 1'b1);
    step(1'b0, 32'h3, 1'b0);
    step(1'b0, 32'h3, 1'b0);

    // Parity pattern.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0103_0700, 1'b0);

    // Reset pulse after lock, then relock with random traffic.
    step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, $urandom, ($urandom_range(0, 4) == 0));

    // Change every cycle long enough to saturate the change counter.
    for (int i = 0; i < 66000; i++) step(1'b0, 32'(i) ^ 32'hA5A5_0000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, $urandom, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
